// File: rtl/uart_tx_buf_if.sv
// Host-side bus of the UART transmitter: baud tick, byte request and status.
//
// Handshake: trmt is a one-cycle request carrying tx_data. It is accepted
// when tx_ready=1 (holding register empty), and also in the frame-end cycle
// even with the holding register full, because the held byte moves into the
// shifter that same cycle. A trmt that cannot be accepted is dropped and
// reported by a one-cycle overrun pulse. There is no back-pressure beyond
// tx_ready; the host is expected to check it before requesting.
interface uart_tx_buf_if;
    logic       brg_en;
    logic       trmt;
    logic [7:0] tx_data;
    logic       TX;
    logic       busy;
    logic       tx_ready;
    logic       tx_done;
    logic       overrun;
    logic [0:0] dbg_state;

    modport master (
        output brg_en, trmt, tx_data,
        input  TX, busy, tx_ready, tx_done, overrun, dbg_state
    );

    modport slave (
        input  brg_en, trmt, tx_data,
        output TX, busy, tx_ready, tx_done, overrun, dbg_state
    );
endinterface

// File: rtl/uart_tx_buf.sv
// 8N1 UART transmitter with a one-deep holding register so back-to-back
// frames leave the line with no idle gap. Bit timing comes from brg_en,
// which pulses OSR times per bit period (shared with the 16x receiver).
module uart_tx_buf #(
    parameter int OSR = 16
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_buf_if.slave  bus
);
    localparam int              BW       = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [BW-1:0]   BAUD_TOP = BW'(OSR - 1);
    localparam logic [3:0]      LAST_BIT = 4'd9;
    localparam logic [0:0]      S_IDLE   = 1'b0;
    localparam logic [0:0]      S_XMIT   = 1'b1;

    if (OSR < 2 || (OSR & (OSR - 1)) != 0) begin : g_bad_osr
        $error("uart_tx_buf: OSR must be a power of 2 and at least 2");
    end

    logic [0:0]    r_state;
    logic [9:0]    r_shift;
    logic [BW-1:0] r_baud_cnt;
    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_hold;
    logic          r_hold_full;
    logic          r_tx_done;
    logic          r_overrun;

    // A bit period ends on the brg_en that finds the baud counter at zero;
    // the frame ends when that shift moves past the stop bit.
    logic w_bit_end;
    logic w_frame_end;

    assign w_bit_end   = (r_state == S_XMIT) && bus.brg_en && (r_baud_cnt == '0);
    assign w_frame_end = w_bit_end && (r_bit_cnt == LAST_BIT);

    // Frame sequencing, shifter, counters and the holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '1;
            r_baud_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_tx_done   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            r_overrun <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // brg_en has no effect here; only a request starts a frame.
                    if (bus.trmt) begin
                        r_shift    <= {1'b1, bus.tx_data, 1'b0};
                        r_baud_cnt <= BAUD_TOP;
                        r_bit_cnt  <= '0;
                        r_state    <= S_XMIT;
                    end
                end
                S_XMIT: begin
                    if (w_frame_end) begin
                        r_tx_done <= 1'b1;
                        if (r_hold_full) begin
                            // Held byte starts immediately; a request arriving
                            // now refills the holding register.
                            r_shift    <= {1'b1, r_hold, 1'b0};
                            r_baud_cnt <= BAUD_TOP;
                            r_bit_cnt  <= '0;
                            if (bus.trmt) begin
                                r_hold <= bus.tx_data;
                            end else begin
                                r_hold_full <= 1'b0;
                            end
                        end else if (bus.trmt) begin
                            // Request coincides with frame end: go straight out.
                            r_shift    <= {1'b1, bus.tx_data, 1'b0};
                            r_baud_cnt <= BAUD_TOP;
                            r_bit_cnt  <= '0;
                        end else begin
                            r_shift   <= '1;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            r_state   <= S_IDLE;
                        end
                    end else begin
                        if (w_bit_end) begin
                            r_shift    <= {1'b1, r_shift[9:1]};
                            r_baud_cnt <= BAUD_TOP;
                            r_bit_cnt  <= r_bit_cnt + 4'd1;
                        end else if (bus.brg_en) begin
                            r_baud_cnt <= r_baud_cnt - 1'b1;
                        end
                        if (bus.trmt) begin
                            if (!r_hold_full) begin
                                r_hold      <= bus.tx_data;
                                r_hold_full <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.TX        = r_shift[0];
    assign bus.busy      = (r_state == S_XMIT);
    assign bus.tx_ready  = ~r_hold_full;
    assign bus.tx_done   = r_tx_done;
    assign bus.overrun   = r_overrun;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: a table of single-cycle vectors followed by
// hand-written multi-cycle sequences checked against a behavioural 8N1
// receiver and an expected-byte queue.
module tb_uart_tx_buf;
  localparam int OSR = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_buf_if bus();

  uart_tx_buf #(.OSR(OSR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int brg_period = 4;
  int div_cnt    = 0;
  int cnt_done   = 0;
  int cnt_ovr    = 0;
  int rx_err     = 0;
  logic       rx_active = 1'b0;
  int         rx_cnt    = 0;
  logic [9:0] rx_bits   = '0;
  logic [9:0] last_frame = '0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  typedef struct {
    logic       brg;
    logic       trmt;
    logic [7:0] data;
    logic       tx;
    logic       busy;
    logic       ready;
    logic       done;
    logic       ovr;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural receiver: start detected on a tick seeing TX=0, bit k
  // sampled 8+16k ticks later (mid-bit).
  task automatic rx_tick();
    int k;
    if (!rx_active) begin
      if (bus.TX == 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= OSR/2 && ((rx_cnt - OSR/2) % OSR) == 0) begin
        k = (rx_cnt - OSR/2) / OSR;
        rx_bits[k] = bus.TX;
        if (k == 9) begin
          rx_active  = 1'b0;
          last_frame = rx_bits;
          got_q.push_back(rx_bits[8:1]);
          if (rx_bits[0] != 1'b0 || rx_bits[9] != 1'b1) rx_err++;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step_raw(input logic brg);
    bus.brg_en = brg;
    @(posedge clk);
    #1;
    if (bus.tx_done) cnt_done++;
    if (bus.overrun) cnt_ovr++;
    if (brg) rx_tick();
  endtask

  task automatic step();
    logic b;
    b = (div_cnt == brg_period - 1);
    div_cnt = (div_cnt + 1) % brg_period;
    step_raw(b);
  endtask

  task automatic send(input logic [7:0] b);
    bus.trmt    = 1'b1;
    bus.tx_data = b;
    step();
    bus.trmt    = 1'b0;
    bus.tx_data = 8'($urandom_range(0, 255));
  endtask

  task automatic reset_model();
    rx_active = 1'b0;
    rx_cnt    = 0;
    cnt_done  = 0;
    cnt_ovr   = 0;
    rx_err    = 0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic run_until_idle(input int max_steps);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < max_steps; i++) begin
      step();
      if (!bus.busy && !rx_active) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_timeout", 32'(ok), 32'd1);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_bytes(input string name);
    int n;
    check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({name, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic check_outputs(input string name, input logic tx, input logic busy,
                               input logic ready, input logic done, input logic ovr);
    check({name, "_TX"},       32'(bus.TX),       32'(tx));
    check({name, "_busy"},     32'(bus.busy),     32'(busy));
    check({name, "_tx_ready"}, 32'(bus.tx_ready), 32'(ready));
    check({name, "_tx_done"},  32'(bus.tx_done),  32'(done));
    check({name, "_overrun"},  32'(bus.overrun),  32'(ovr));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    int ticks;
    int bad;
    logic found;

    // Expected values after the edge that applies each row's inputs.
    vecs[0] = '{brg:1'b1, trmt:1'b0, data:8'h00, tx:1'b1, busy:1'b0, ready:1'b1, done:1'b0, ovr:1'b0};
    vecs[1] = '{brg:1'b0, trmt:1'b1, data:8'hA5, tx:1'b0, busy:1'b1, ready:1'b1, done:1'b0, ovr:1'b0};
    vecs[2] = '{brg:1'b0, trmt:1'b1, data:8'h5A, tx:1'b0, busy:1'b1, ready:1'b0, done:1'b0, ovr:1'b0};
    vecs[3] = '{brg:1'b0, trmt:1'b1, data:8'hFF, tx:1'b0, busy:1'b1, ready:1'b0, done:1'b0, ovr:1'b1};
    vecs[4] = '{brg:1'b0, trmt:1'b0, data:8'h00, tx:1'b0, busy:1'b1, ready:1'b0, done:1'b0, ovr:1'b0};

    bus.brg_en  = 1'b0;
    bus.trmt    = 1'b0;
    bus.tx_data = 8'h00;

    // Reset state
    rst = 1'b1;
    step_raw(1'b0);
    step_raw(1'b0);
    rst = 1'b0;
    check_outputs("reset", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("reset_state", 32'(bus.dbg_state), 32'd0);

    // Table vectors: idle tick, load, hold capture, overrun, overrun clears
    for (int i = 0; i < 5; i++) begin
      bus.trmt    = vecs[i].trmt;
      bus.tx_data = vecs[i].data;
      step_raw(vecs[i].brg);
      check_outputs($sformatf("vec%0d", i), vecs[i].tx, vecs[i].busy,
                    vecs[i].ready, vecs[i].done, vecs[i].ovr);
    end
    bus.trmt = 1'b0;
    rst = 1'b1;
    step_raw(1'b0);
    rst = 1'b0;
    check_outputs("table_reset", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    reset_model();

    // Idle: 20 brg_en ticks with no request
    brg_period = 4;
    div_cnt    = 0;
    bad = 0;
    for (int i = 0; i < 20 * 4; i++) begin
      step();
      if (bus.TX !== 1'b1 || bus.busy !== 1'b0 || bus.tx_ready !== 1'b1 ||
          bus.tx_done !== 1'b0 || bus.overrun !== 1'b0) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);

    // 0xA5 single frame: 160 ticks, TX sequence 0,1,0,1,0,0,1,0,1,1
    reset_model();
    send(8'hA5);
    exp_q.push_back(8'hA5);
    check("a5_start_TX", 32'(bus.TX), 32'd0);
    ticks = 0;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (bus.brg_en) ticks++;
      if (bus.tx_done) begin
        found = 1'b1;
        break;
      end
    end
    check("a5_done_seen", 32'(found), 32'd1);
    check("a5_ticks", 32'(ticks), 32'(10 * OSR));
    check("a5_bits", 32'(last_frame), 32'(10'b11_0100_1010));
    step();
    check("a5_busy_after", 32'(bus.busy), 32'd0);
    check("a5_done_once", 32'(bus.tx_done), 32'd0);
    check("a5_TX_after", 32'(bus.TX), 32'd1);
    check("a5_done_count", 32'(cnt_done), 32'd1);
    check_bytes("a5");

    // 0x3C then 0xC3 queued mid-frame: zero-gap back-to-back
    reset_model();
    send(8'h3C);
    exp_q.push_back(8'h3C);
    for (int i = 0; i < 100; i++) step();
    send(8'hC3);
    exp_q.push_back(8'hC3);
    check("b2b_ready_drop", 32'(bus.tx_ready), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (bus.tx_done) begin
        found = 1'b1;
        break;
      end
    end
    check("b2b_first_done", 32'(found), 32'd1);
    check("b2b_gap_TX", 32'(bus.TX), 32'd0);
    check("b2b_gap_busy", 32'(bus.busy), 32'd1);
    check("b2b_ready_back", 32'(bus.tx_ready), 32'd1);
    run_until_idle(3000);
    check("b2b_done_count", 32'(cnt_done), 32'd2);
    check("b2b_frame_err", 32'(rx_err), 32'd0);
    check_bytes("b2b");

    // Overrun: 0x01, 0x02 queued, 0x03 dropped
    reset_model();
    send(8'h01);
    exp_q.push_back(8'h01);
    for (int i = 0; i < 40; i++) step();
    send(8'h02);
    exp_q.push_back(8'h02);
    check("ovr_hold_full", 32'(bus.tx_ready), 32'd0);
    for (int i = 0; i < 40; i++) step();
    send(8'h03);
    check("ovr_pulse", 32'(bus.overrun), 32'd1);
    step();
    check("ovr_pulse_end", 32'(bus.overrun), 32'd0);
    run_until_idle(3000);
    check("ovr_count", 32'(cnt_ovr), 32'd1);
    check("ovr_done_count", 32'(cnt_done), 32'd2);
    check_bytes("ovr");

    // Reset during data bit 3 of 0xFF, then a clean 0x55 frame
    reset_model();
    send(8'hFF);
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (rx_active && rx_cnt >= 4 * OSR + OSR/2) begin
        found = 1'b1;
        break;
      end
    end
    check("rstmid_reached", 32'(found), 32'd1);
    rst = 1'b1;
    step_raw(1'b0);
    rst = 1'b0;
    check_outputs("rstmid", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    reset_model();
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (bus.TX !== 1'b1 || bus.busy !== 1'b0 || bus.tx_done !== 1'b0) bad++;
    end
    check("rstmid_no_partial", 32'(bad), 32'd0);
    send(8'h55);
    exp_q.push_back(8'h55);
    run_until_idle(3000);
    check("rstmid_done_count", 32'(cnt_done), 32'd1);
    check("rstmid_frame_err", 32'(rx_err), 32'd0);
    check_bytes("rstmid");

    // Loopback: 256 bytes back-to-back, brg_en every clock
    reset_model();
    brg_period = 1;
    div_cnt    = 0;
    for (int b = 0; b < 256; b++) begin
      for (int w = 0; w < 1000 && !bus.tx_ready; w++) step();
      if (!bus.tx_ready) begin
        check("loop_ready_timeout", 32'(bus.tx_ready), 32'd1);
        break;
      end
      send(8'(b));
      exp_q.push_back(8'(b));
    end
    run_until_idle(5000);
    check("loop_overrun", 32'(cnt_ovr), 32'd0);
    check("loop_done_count", 32'(cnt_done), 32'd256);
    check("loop_frame_err", 32'(rx_err), 32'd0);
    check_bytes("loop");

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_buf.md
Name: uart_tx_buf

Overview:
- Transmit side of the team's UART; pairs with the existing 16x-oversampled receiver on the same baud-rate generator tick (brg_en).
- Serializes 8-bit bytes as 8N1 frames: start bit 0, data LSB first, stop bit 1.
- Adds a one-deep holding register so the host can queue the next byte while a frame is on the line. Back-to-back frames then go out with no idle gap.

Parameters:
- OSR, 16, brg_en pulses per bit period; must be a power of 2 and at least 2. Baud counter width is log2(OSR).

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- brg_en  input  1  one-cycle baud tick at OSR x baud rate
- trmt  input  1  one-cycle request to send tx_data
- tx_data  input  8  byte to send; sampled only in a cycle where trmt=1
- TX  output  1  serial line, idles high
- busy  output  1  frame in progress on TX
- tx_ready  output  1  holding register empty; a trmt now is accepted
- tx_done  output  1  one-cycle pulse at the end of each frame's stop bit
- overrun  output  1  one-cycle pulse when a trmt is dropped

Behaviour:
- Reset (rst=1 at posedge clk), including mid-frame:
  - next edge gives TX=1, busy=0, tx_ready=1, tx_done=0, overrun=0
  - holding register cleared; state=IDLE; counters cleared
  - no partial frame is completed
- Datapath:
  - 10-bit shift register loaded with {1'b1, data, 1'b0}
  - TX is driven from the register's LSB; it shifts right and fills with 1
- Counters:
  - baud_cnt is loaded to OSR-1 on frame load and decrements on each brg_en.
  - When baud_cnt==0 and brg_en=1: shift, reload OSR-1, bit_cnt++.
  - Every bit lasts exactly OSR brg_en pulses.
  - bit_cnt counts 0..10 and is cleared on load.
- State machine IDLE / TRANSMITTING:
  - IDLE, trmt=1: load shifter from tx_data. Next cycle: TX=0, busy=1, state=TRANSMITTING. tx_ready stays 1.
  - TRANSMITTING, trmt=1, hold empty: capture tx_data into hold. tx_ready=0 next cycle.
  - TRANSMITTING, trmt=1, hold full: byte dropped, overrun=1 for one cycle. Hold keeps its old byte.
  - Frame end is the shift that takes bit_cnt to 10, i.e. the end of the stop bit. tx_done=1 for one cycle after that edge. Then:
    - hold full: load shifter from hold, hold becomes empty, stay TRANSMITTING. The next start bit begins the cycle after the stop bit ends. busy stays 1.
    - hold empty: go to IDLE, busy=0, TX=1.
- Simultaneous events at the frame-end cycle:
  - hold empty and trmt=1: tx_data loads straight into the shifter (back-to-back), no overrun.
  - hold full and trmt=1: hold moves to the shifter and tx_data goes into hold. Accepted, no overrun.
- brg_en is ignored in IDLE.
- A trmt in the same cycle as the IDLE load is impossible, because trmt is a single cycle.
- tx_data is don't-care when trmt=0.
- Latency: TX falls one clk after an accepted trmt in IDLE. A frame lasts 10*OSR brg_en pulses.

Test Plan:
- Reset, then 20 brg_en with no trmt -> TX=1, busy=0, tx_ready=1, no tx_done or overrun.
- trmt with 0xA5 in IDLE, brg_en every 4 clk -> TX sequence 0,1,0,1,0,0,1,0,1,1; each bit 16 brg_en (64 clk). One tx_done pulse at the stop-bit end, then busy=0.
- Send 0x3C, then trmt 0xC3 mid-frame:
  - tx_ready drops
  - 0xC3 start bit follows the 0x3C stop bit with zero idle cycles
  - two tx_done pulses total
  - tx_ready returns to 1 at the second load
- Send 0x01, queue 0x02, trmt 0x03 while hold full -> overrun pulses once. Only 0x01 and 0x02 appear on TX.
- rst asserted during data bit 3 of 0xFF -> next edge TX=1, busy=0, tx_ready=1. A later trmt 0x55 produces a clean full frame.
- Loopback: TX into the existing receiver, 256 bytes 0x00..0xFF queued back-to-back -> every byte received in order, receiver rdy once per byte, no overrun.
